// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: pipelined control decode with load-use stall, branch/jump flush and illegal-opcode count
module pipe_ctrl_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W = 2,
  parameter int REG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [OPCODE_W-1:0] id_opcode,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                ex_branch_taken,
  output logic                stall,
  output logic                if_flush,
  output logic                id_jump,
  output logic                ex_valid,
  output logic                ex_reg_dst,
  output logic                ex_alu_src,
  output logic                ex_branch,
  output logic                ex_branch_ne,
  output logic [ALUOP_W-1:0]  ex_alu_op,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_mem_to_reg,
  output logic                ex_reg_write,
  output logic [REG_W-1:0]    ex_rt,
  output logic                ex_illegal,
  output logic                mem_valid,
  output logic                mem_mem_read,
  output logic                mem_mem_write,
  output logic                mem_mem_to_reg,
  output logic                mem_reg_write,
  output logic                wb_valid,
  output logic                wb_mem_to_reg,
  output logic                wb_reg_write,
  output logic [CNT_W-1:0]    illegal_cnt
);
  logic is_r, is_lw, is_sw, is_beq, is_bne, is_addi, is_j, d_illegal;
  logic hazard, flush, load;
  logic [ALUOP_W-1:0] d_alu_op;
  assign is_r      = id_opcode == OPCODE_W'(6'b000000);
  assign is_lw     = id_opcode == OPCODE_W'(6'b100011);
  assign is_sw     = id_opcode == OPCODE_W'(6'b101011);
  assign is_beq    = id_opcode == OPCODE_W'(6'b000100);
  assign is_bne    = id_opcode == OPCODE_W'(6'b000101);
  assign is_addi   = id_opcode == OPCODE_W'(6'b001000);
  assign is_j      = id_opcode == OPCODE_W'(6'b000010);
  assign d_illegal = ~(is_r | is_lw | is_sw | is_beq | is_bne | is_addi | is_j);
  assign d_alu_op  = is_r ? ALUOP_W'(2'b10) : (is_beq | is_bne) ? ALUOP_W'(2'b01) : '0;
  assign flush     = ex_valid & ex_branch & ex_branch_taken;
  assign hazard    = id_valid & ex_valid & ex_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign stall     = hazard & ~flush;
  assign id_jump   = id_valid & is_j;
  assign if_flush  = flush | id_jump;
  assign load      = id_valid & ~flush & ~hazard;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid       <= 1'b0;
      ex_reg_dst     <= 1'b0;
      ex_alu_src     <= 1'b0;
      ex_branch      <= 1'b0;
      ex_branch_ne   <= 1'b0;
      ex_alu_op      <= '0;
      ex_mem_read    <= 1'b0;
      ex_mem_write   <= 1'b0;
      ex_mem_to_reg  <= 1'b0;
      ex_reg_write   <= 1'b0;
      ex_rt          <= '0;
      ex_illegal     <= 1'b0;
      mem_valid      <= 1'b0;
      mem_mem_read   <= 1'b0;
      mem_mem_write  <= 1'b0;
      mem_mem_to_reg <= 1'b0;
      mem_reg_write  <= 1'b0;
      wb_valid       <= 1'b0;
      wb_mem_to_reg  <= 1'b0;
      wb_reg_write   <= 1'b0;
      illegal_cnt    <= '0;
    end else begin
      ex_valid       <= load;
      ex_reg_dst     <= load & is_r;
      ex_alu_src     <= load & (is_lw | is_sw | is_addi);
      ex_branch      <= load & (is_beq | is_bne);
      ex_branch_ne   <= load & is_bne;
      ex_alu_op      <= load ? d_alu_op : '0;
      ex_mem_read    <= load & is_lw;
      ex_mem_write   <= load & is_sw;
      ex_mem_to_reg  <= load & is_lw;
      ex_reg_write   <= load & (is_r | is_lw | is_addi);
      ex_rt          <= load ? id_rt : '0;
      ex_illegal     <= load & d_illegal;
      mem_valid      <= ex_valid;
      mem_mem_read   <= ex_mem_read;
      mem_mem_write  <= ex_mem_write;
      mem_mem_to_reg <= ex_mem_to_reg;
      mem_reg_write  <= ex_reg_write;
      wb_valid       <= mem_valid;
      wb_mem_to_reg  <= mem_mem_to_reg;
      wb_reg_write   <= mem_reg_write;
      if (load & d_illegal & (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + 1'b1;
    end
  end
endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle opcode decoder.
- Decodes the ID-stage opcode into the control bundle (reg_dst, jump, branch, mem_read, mem_to_reg, alu_op, mem_write, alu_src, reg_write) and carries it through ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use stall detection, branch/jump flush, bne support and an illegal-opcode counter.
- Sits beside the datapath pipeline registers; the datapath consumes the stage-qualified control outputs.

Parameters:
OPCODE_W, 6, opcode field width
ALUOP_W, 2, alu_op width
REG_W, 5, register specifier width
CNT_W, 8, illegal-opcode counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_opcode  in  OPCODE_W  ID-stage opcode
id_rs  in  REG_W  ID-stage rs
id_rt  in  REG_W  ID-stage rt
ex_branch_taken  in  1  datapath branch-condition result for the EX instruction
stall  out  1  combinational; hold PC and IF/ID
if_flush  out  1  combinational; clear IF/ID
id_jump  out  1  combinational; jump decoded in ID
ex_valid, ex_reg_dst, ex_alu_src, ex_branch, ex_branch_ne  out  1 each  ID/EX controls
ex_alu_op  out  ALUOP_W  ID/EX alu_op
ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write  out  1 each  ID/EX controls
ex_rt  out  REG_W  registered id_rt
ex_illegal  out  1  EX instruction had an illegal opcode
mem_valid, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_reg_write  out  1 each  EX/MEM controls
wb_valid, wb_mem_to_reg, wb_reg_write  out  1 each  MEM/WB controls
illegal_cnt  out  CNT_W  saturating illegal-opcode count

Behaviour:
- Reset: rst_n low asynchronously clears every register. All stage outputs, ex_rt and illegal_cnt read 0, so every stage holds a bubble. Reset mid-operation discards in-flight instructions.
- Decode (id_valid=1). Unlisted bundle bits are 0.
  - 000000 R: reg_dst=1, reg_write=1, alu_op=10.
  - 100011 lw: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=00.
  - 101011 sw: alu_src=1, mem_write=1, alu_op=00.
  - 000100 beq: branch=1, alu_op=01.
  - 000101 bne: branch=1, branch_ne=1, alu_op=01.
  - 001000 addi: alu_src=1, reg_write=1, alu_op=00.
  - 000010 j: jump=1 only.
  - Any other opcode: all zero, illegal=1.
- id_jump = id_valid & decoded jump.
- Load-use hazard:
  - hazard = id_valid & ex_valid & ex_mem_read & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
  - stall = hazard & ~flush.
- Flush:
  - flush = ex_valid & ex_branch & ex_branch_taken.
  - if_flush = flush | id_jump.
- ID/EX update, each clock:
  - Loads a bubble (all zero, ex_valid=0) if flush, stall or ~id_valid.
  - Otherwise loads the decoded bundle, id_rt and illegal, with ex_valid=1.
  - A jump enters EX as a valid no-write instruction.
- EX/MEM and MEM/WB always advance: mem_* <= ex_* (mem_valid <= ex_valid), wb_* <= mem_*. They are never stalled or flushed.
- Stall length: exactly 1 cycle per load-use pair. After the bubble the lw is in MEM and the hazard clears.
- Simultaneous events: flush has priority over stall and over id_jump. if_flush stays 1 and the bubble is inserted.
- illegal_cnt increments by 1 when an illegal instruction is loaded into ID/EX, not when it is stalled or flushed. It saturates at 2^CNT_W-1 with no wrap.
- Latency: control for an ID instruction appears on ex_* 1 cycle later, mem_* 2 cycles later and wb_* 3 cycles later, absent stalls.

Test Plan:
- Reset then R-type (id_opcode=000000, id_valid=1) -> next cycle ex_reg_dst=1, ex_reg_write=1, ex_alu_op=10. mem_reg_write=1 one cycle later, wb_reg_write=1 one cycle after that.
- lw with rt=5, followed by an instruction with rs=5 -> stall=1 for exactly one cycle. ex_valid=0 in the next cycle, then the dependent instruction reaches EX. Repeating with rt=0 -> stall never asserts.
- beq in EX with ex_branch_taken=1 while ID holds a hazard-causing instruction -> if_flush=1, stall=0, next ex_valid=0. With ex_branch_taken=0 -> no flush.
- id_opcode=000010 -> id_jump=1 and if_flush=1 the same cycle. Next cycle ex_valid=1 with all write controls 0.
- id_opcode=111111, id_valid=1 -> ex_illegal=1 and illegal_cnt=1. With CNT_W=2, feed 5 illegal instructions -> illegal_cnt holds at 3.
- Assert rst_n=0 mid-stream with valid instructions in all stages -> all outputs read 0 immediately, without waiting for a clock edge.
